// File: rtl/softusb_crc_pkg.sv
// Shared constants for the soft USB receive-path CRC checkers.
package softusb_crc_pkg;

  localparam int unsigned CRC5_W  = 5;
  localparam int unsigned CRC16_W = 16;

  localparam logic [CRC5_W-1:0]  POLY5   = 5'h05;
  localparam logic [CRC5_W-1:0]  INIT5   = 5'h1F;
  localparam logic [CRC5_W-1:0]  RESID5  = 5'h0C;

  localparam logic [CRC16_W-1:0] POLY16  = 16'h8005;
  localparam logic [CRC16_W-1:0] INIT16  = 16'hFFFF;
  localparam logic [CRC16_W-1:0] RESID16 = 16'h800D;

endpackage

// File: rtl/softusb_crc_lfsr.sv
// Serial Galois-LFSR CRC register with synchronous preset and residual compare.
module softusb_crc_lfsr #(
  parameter int unsigned       WIDTH = 5,
  parameter logic [WIDTH-1:0]  POLY  = '0,
  parameter logic [WIDTH-1:0]  INIT  = '1,
  parameter logic [WIDTH-1:0]  RESID = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             din,
  output logic [WIDTH-1:0] crc,
  output logic             match_c
);

  logic [WIDTH-1:0] crc_q;
  logic [WIDTH-1:0] crc_d;
  logic             fb;

  // One bit per enable: shift left, fold the polynomial in when feedback is set.
  always_comb begin
    fb    = 1'b0;
    crc_d = crc_q;
    if (ce) begin
      fb    = crc_q[WIDTH-1] ^ din;
      crc_d = {crc_q[WIDTH-2:0], 1'b0} ^ (fb ? POLY : WIDTH'(0));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc     = crc_q;
  assign match_c = (crc_q == RESID);

endmodule

// File: rtl/soft_usb_crc.sv
// USB receive CRC checker: CRC5 and CRC16 registers fed in parallel from one serial bit.
module soft_usb_crc
  import softusb_crc_pkg::*;
(
  input  logic usb_clk,
  input  logic crc_reset,
  input  logic crc_ce,
  input  logic data,
  output logic crc5_valid,
  output logic crc16_valid
);

  logic [CRC5_W-1:0]  crc5;
  logic [CRC16_W-1:0] crc16;

  softusb_crc_lfsr #(
    .WIDTH (CRC5_W),
    .POLY  (POLY5),
    .INIT  (INIT5),
    .RESID (RESID5)
  ) u_crc5 (
    .clk     (usb_clk),
    .rst     (crc_reset),
    .ce      (crc_ce),
    .din     (data),
    .crc     (crc5),
    .match_c (crc5_valid)
  );

  softusb_crc_lfsr #(
    .WIDTH (CRC16_W),
    .POLY  (POLY16),
    .INIT  (INIT16),
    .RESID (RESID16)
  ) u_crc16 (
    .clk     (usb_clk),
    .rst     (crc_reset),
    .ce      (crc_ce),
    .din     (data),
    .crc     (crc16),
    .match_c (crc16_valid)
  );

endmodule

// File: tb/tb_soft_usb_crc.sv
// Self-checking bench for soft_usb_crc against a polynomial long-division model.
module tb_soft_usb_crc;

  logic usb_clk;
  logic crc_reset;
  logic crc_ce;
  logic data;
  logic crc5_valid;
  logic crc16_valid;

  int n_tests;
  int n_fail;

  bit sent[$];

  soft_usb_crc dut (
    .usb_clk     (usb_clk),
    .crc_reset   (crc_reset),
    .crc_ce      (crc_ce),
    .data        (data),
    .crc5_valid  (crc5_valid),
    .crc16_valid (crc16_valid)
  );

  initial usb_clk = 1'b0;
  always #5 usb_clk = ~usb_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Remainder of (M(x) * x^w + ones(w) * x^n) mod G(x), the all-ones preset folded in.
  function automatic logic [15:0] ref_crc(input bit msg[$], input int unsigned w,
                                          input logic [16:0] gen);
    bit          a[];
    int          n;
    logic [15:0] r;
    n = msg.size();
    r = '0;
    a = new[n + int'(w)];
    foreach (a[i]) a[i] = 1'b0;
    for (int i = 0; i < n; i++) a[i] = msg[i];
    for (int i = 0; i < int'(w); i++) a[i] = a[i] ^ 1'b1;
    for (int i = 0; i < n; i++) begin
      if (a[i]) begin
        for (int j = 0; j <= int'(w); j++) a[i+j] = a[i+j] ^ gen[int'(w)-j];
      end
    end
    for (int i = 0; i < int'(w); i++) r = {r[14:0], a[n+i]};
    return r;
  endfunction

  function automatic logic [15:0] exp5();
    return ref_crc(sent, 5, 17'h00025);
  endfunction

  function automatic logic [15:0] exp16();
    return ref_crc(sent, 16, 17'h18005);
  endfunction

  task automatic check_all(input string tag);
    logic [15:0] e5;
    logic [15:0] e16;
    e5  = exp5();
    e16 = exp16();
    check({tag, " crc5"},  32'(dut.crc5),  32'(e5));
    check({tag, " crc16"}, 32'(dut.crc16), 32'(e16));
    check({tag, " v5"},    32'(crc5_valid),  32'(e5 == 16'h000C));
    check({tag, " v16"},   32'(crc16_valid), 32'(e16 == 16'h800D));
  endtask

  task automatic do_reset();
    @(negedge usb_clk);
    crc_reset = 1'b1;
    crc_ce    = 1'b0;
    data      = 1'($urandom);
    @(negedge usb_clk);
    crc_reset = 1'b0;
    sent.delete();
  endtask

  // Enabled cycle followed by a disabled cycle with random data.
  task automatic send_bit(input bit b);
    @(negedge usb_clk);
    crc_ce = 1'b1;
    data   = b;
    sent.push_back(b);
    @(negedge usb_clk);
    crc_ce = 1'b0;
    data   = 1'($urandom);
  endtask

  task automatic send_word(input logic [47:0] v, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  logic [15:0] tokens [4] = '{16'h08F4, 16'hA8F7, 16'h0E4E, 16'h8017};
  logic [47:0] dpkts  [2] = '{48'h008040C0F75E, 48'hC4A2E6917038};

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    crc_reset = 1'b0;
    crc_ce    = 1'b0;
    data      = 1'b0;

    do_reset();
    check("rst crc5",  32'(dut.crc5),  32'h1F);
    check("rst crc16", 32'(dut.crc16), 32'hFFFF);
    check("rst v5",    32'(crc5_valid),  32'd0);
    check("rst v16",   32'(crc16_valid), 32'd0);

    foreach (tokens[k]) begin
      do_reset();
      send_word(48'(tokens[k]), 16);
      check($sformatf("tok%0d crc5 resid", k), 32'(dut.crc5), 32'h0C);
      check($sformatf("tok%0d v5", k), 32'(crc5_valid), 32'd1);
      check_all($sformatf("tok%0d", k));
    end

    foreach (dpkts[k]) begin
      do_reset();
      send_word(dpkts[k], 48);
      check($sformatf("data%0d crc16 resid", k), 32'(dut.crc16), 32'h800D);
      check($sformatf("data%0d v16", k), 32'(crc16_valid), 32'd1);
      check_all($sformatf("data%0d", k));
    end

    do_reset();
    send_word(48'h08F5, 16);
    check("corrupt v5", 32'(crc5_valid), 32'd0);
    check_all("corrupt");

    // Enable held low mid-token while data toggles.
    do_reset();
    send_word(48'h08, 8);
    for (int i = 0; i < 20; i++) begin
      @(negedge usb_clk);
      crc_ce = 1'b0;
      data   = ~data;
    end
    check_all("hold");
    send_word(48'hF4, 8);
    check("hold v5", 32'(crc5_valid), 32'd1);
    check_all("hold done");

    // Reset wins over a simultaneous enable.
    do_reset();
    send_word(48'hA8, 8);
    @(negedge usb_clk);
    crc_reset = 1'b1;
    crc_ce    = 1'b1;
    data      = 1'b1;
    @(negedge usb_clk);
    crc_reset = 1'b0;
    crc_ce    = 1'b0;
    sent.delete();
    check("midrst crc5",  32'(dut.crc5),  32'h1F);
    check("midrst crc16", 32'(dut.crc16), 32'hFFFF);
    check("midrst v5",    32'(crc5_valid),  32'd0);
    check("midrst v16",   32'(crc16_valid), 32'd0);
    send_word(48'hA8F7, 16);
    check("resend v5", 32'(crc5_valid), 32'd1);
    check_all("resend");

    // Random packets with sparse enables, compared after every bit.
    for (int p = 0; p < 20; p++) begin
      int len;
      do_reset();
      len = int'($urandom_range(1, 64));
      for (int i = 0; i < len; i++) begin
        int gap;
        gap = int'($urandom_range(0, 3));
        for (int g = 0; g < gap; g++) begin
          @(negedge usb_clk);
          crc_ce = 1'b0;
          data   = 1'($urandom);
        end
        send_bit(1'($urandom));
        check_all($sformatf("rnd%0d.%0d", p, i));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
